// File: rtl/video_fetch.sv
// video_fetch
// Video scan-out fetch engine. Walks a raster, fetches frame-buffer bytes
// through the shared memory port during video slots, buffers them in a
// 4-entry FIFO and serialises them MSB first as a 1-bit-per-pixel stream.
//
// Ports:
//   mem_phi   in   1  clock, all state updates on the rising edge
//   rst       in   1  synchronous active-high reset
//   cpu_phi   in   1  high = the current memory slot belongs to video
//   ram_dbo   in   8  RAM read data
//   vid_adr   out 16  video fetch address
//   pixel     out  1  pixel value (0 outside the visible area)
//   active    out  1  high inside the visible area
//   hsync     out  1  active-high horizontal sync
//   vsync     out  1  active-high vertical sync
//   underrun  out  1  sticky: FIFO was empty when a byte was needed
//
// Handshake: the fetch request is implicit. While the fetch FSM is in REQ,
// vid_adr is stable and any edge with cpu_phi=1 is a grant. Read data is
// sampled exactly FETCH_LAT edges after the grant. There is no back-pressure
// on the memory side, so the FSM only enters REQ when a FIFO slot is free.
module video_fetch #(
  parameter logic [15:0] BASE_ADR = 16'h2000,
  parameter int H_ACTIVE  = 256,
  parameter int H_TOTAL   = 320,
  parameter int V_ACTIVE  = 192,
  parameter int V_TOTAL   = 262,
  parameter int HS_START  = 272,
  parameter int HS_LEN    = 24,
  parameter int VS_START  = 220,
  parameter int VS_LEN    = 3,
  parameter int FETCH_LAT = 2
) (
  input  logic        mem_phi,
  input  logic        rst,
  input  logic        cpu_phi,
  input  logic [7:0]  ram_dbo,
  output logic [15:0] vid_adr,
  output logic        pixel,
  output logic        active,
  output logic        hsync,
  output logic        vsync,
  output logic        underrun
);

  localparam int HW          = $clog2(H_TOTAL + 1);
  localparam int VW          = $clog2(V_TOTAL + 1);
  localparam int TOTAL_BYTES = (H_ACTIVE / 8) * V_ACTIVE;
  localparam int BW          = $clog2(TOTAL_BYTES + 1);
  localparam int LW          = (FETCH_LAT > 1) ? $clog2(FETCH_LAT) : 1;

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_S    = HW'(HS_START);
  localparam logic [HW-1:0] HS_E    = HW'(HS_START + HS_LEN);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_S    = VW'(VS_START);
  localparam logic [VW-1:0] VS_E    = VW'(VS_START + VS_LEN);
  localparam logic [BW-1:0] TOTAL_C = BW'(TOTAL_BYTES);
  localparam logic [LW-1:0] LAT_END = LW'(FETCH_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } fetch_state_e;

  // Registered state
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  fetch_state_e  state_q, state_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [15:0]   adr_q, adr_d;
  logic [BW-1:0] fetched_q, fetched_d;
  logic [7:0]    fifo_q [4];
  logic [7:0]    fifo_d [4];
  logic [1:0]    wr_ptr_q, wr_ptr_d;
  logic [1:0]    rd_ptr_q, rd_ptr_d;
  logic [2:0]    count_q, count_d;
  logic [7:0]    shift_q, shift_d;
  logic          pixel_q, pixel_d;
  logic          active_q, active_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          underrun_q, underrun_d;

  // Combinational helpers
  logic       h_wrap;
  logic       restart;
  logic       pop;
  logic       popped;
  logic       push;
  logic [7:0] pop_byte;

  always_comb begin
    // Raster position that the outputs will show after this edge
    h_wrap  = (h_cnt_q == H_LAST);
    h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
    end
    restart = (v_cnt_q == V_LAST) && (h_cnt_q == '0);

    active_d = (h_cnt_d < H_ACT) && (v_cnt_d < V_ACT);
    hsync_d  = (h_cnt_d >= HS_S) && (h_cnt_d < HS_E);
    vsync_d  = (v_cnt_d >= VS_S) && (v_cnt_d < VS_E);

    // Pixel shifter: a new byte is needed at every 8-pixel boundary
    pop        = active_d && (h_cnt_d[2:0] == 3'd0);
    pop_byte   = (count_q == 3'd0) ? 8'h00 : fifo_q[rd_ptr_q];
    popped     = pop && (count_q != 3'd0);
    shift_d    = shift_q;
    pixel_d    = 1'b0;
    underrun_d = underrun_q;
    rd_ptr_d   = rd_ptr_q;
    if (pop) begin
      shift_d = pop_byte;
      pixel_d = pop_byte[7];
      if (count_q == 3'd0) begin
        underrun_d = 1'b1;
      end else begin
        rd_ptr_d = rd_ptr_q + 2'd1;
      end
    end else if (active_d) begin
      shift_d = {shift_q[6:0], 1'b0};
      pixel_d = shift_q[6];
    end

    // Fetch FSM
    state_d   = state_q;
    lat_d     = lat_q;
    adr_d     = adr_q;
    fetched_d = fetched_q;
    push      = 1'b0;
    case (state_q)
      ST_IDLE: ;
      ST_REQ: begin
        if (cpu_phi) begin
          state_d = ST_WAIT;
          lat_d   = '0;
        end
      end
      ST_WAIT: begin
        if (lat_q == LAT_END) begin
          push = 1'b1;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      default: state_d = ST_REQ;
    endcase

    // FIFO write side
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    if (push) begin
      fifo_d[wr_ptr_q] = ram_dbo;
      wr_ptr_d         = wr_ptr_q + 2'd1;
      fetched_d        = fetched_q + 1'b1;
      // The address parks on the last byte of the frame
      if (fetched_d != TOTAL_C) begin
        adr_d = adr_q + 16'd1;
      end
    end

    count_d = count_q;
    if (push && !popped) begin
      count_d = count_q + 3'd1;
    end else if (!push && popped) begin
      count_d = count_q - 3'd1;
    end

    // REQ is only entered with a free slot, which the outstanding fetch
    // then owns; this keeps pushes from ever landing on a full FIFO.
    if ((state_q == ST_IDLE) || push) begin
      state_d = ((count_d != 3'd4) && (fetched_d != TOTAL_C)) ? ST_REQ : ST_IDLE;
    end

    // Frame restart overrides everything on the fetch side, including a push
    if (restart) begin
      state_d   = ST_REQ;
      lat_d     = '0;
      adr_d     = BASE_ADR;
      fetched_d = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
    end
  end

  always_ff @(posedge mem_phi) begin
    if (rst) begin
      h_cnt_q    <= '0;
      v_cnt_q    <= V_LAST;
      state_q    <= ST_REQ;
      lat_q      <= '0;
      adr_q      <= BASE_ADR;
      fetched_q  <= '0;
      for (int i = 0; i < 4; i++) begin
        fifo_q[i] <= 8'h00;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      shift_q    <= 8'h00;
      pixel_q    <= 1'b0;
      active_q   <= 1'b0;
      hsync_q    <= 1'b0;
      vsync_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      state_q    <= state_d;
      lat_q      <= lat_d;
      adr_q      <= adr_d;
      fetched_q  <= fetched_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      shift_q    <= shift_d;
      pixel_q    <= pixel_d;
      active_q   <= active_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      underrun_q <= underrun_d;
    end
  end

  assign vid_adr  = adr_q;
  assign pixel    = pixel_q;
  assign active   = active_q;
  assign hsync    = hsync_q;
  assign vsync    = vsync_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_video_fetch.sv
// tb_video_fetch
// Drives video_fetch with a reduced raster so whole frames stay short, and
// compares every output on every cycle against a queue/timestamp reference
// model of the fetch engine, plus directed checks on pixel order, sync
// windows, address parking, starvation and reset during a fetch.
module tb_video_fetch;

  localparam logic [15:0] BASE = 16'h2000;
  localparam int HA    = 32;
  localparam int HT    = 48;
  localparam int VA    = 6;
  localparam int VT    = 10;
  localparam int HSS   = 36;
  localparam int HSL   = 4;
  localparam int VSS   = 7;
  localparam int VSL   = 2;
  localparam int LAT   = 2;
  localparam int TOTAL = (HA / 8) * VA;
  localparam int FRAME = HT * VT;

  // Clock / reset
  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_phi;
  logic [7:0]  ram_dbo;
  logic [15:0] vid_adr;
  logic        pixel, active, hsync, vsync, underrun;

  always #5 clk = ~clk;

  video_fetch #(
    .BASE_ADR (BASE), .H_ACTIVE (HA), .H_TOTAL (HT), .V_ACTIVE (VA),
    .V_TOTAL (VT), .HS_START (HSS), .HS_LEN (HSL), .VS_START (VSS),
    .VS_LEN (VSL), .FETCH_LAT (LAT)
  ) dut (
    .mem_phi  (clk),
    .rst      (rst),
    .cpu_phi  (cpu_phi),
    .ram_dbo  (ram_dbo),
    .vid_adr  (vid_adr),
    .pixel    (pixel),
    .active   (active),
    .hsync    (hsync),
    .vsync    (vsync),
    .underrun (underrun)
  );

  // RAM contents as a pure function of address; data is held stable while
  // the address is stable, which covers any FETCH_LAT.
  function automatic logic [7:0] ram_fn(input logic [15:0] a);
    logic [7:0] r;
    if (a == BASE) r = 8'hA5;
    else           r = (a[7:0] * 8'd29) + 8'h11;
    return r;
  endfunction

  assign ram_dbo = ram_fn(vid_adr);

  // Scoreboard counters
  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  // Reference model state
  int          m_h, m_v, m_cyc, m_push_at, m_fetched;
  bit          m_out;
  logic [7:0]  exp_q[$];
  logic [15:0] m_adr;
  logic [7:0]  m_sh;
  logic        e_pix, e_act, e_hs, e_vs, e_und;
  logic [7:0]  a5_byte;

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b (v=%0d h=%0d)", tag, obs, exp, m_v, m_h);
    end
  endtask

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (v=%0d h=%0d)", tag, obs, exp, m_v, m_h);
    end
  endtask

  // One clock edge of the reference model.
  task automatic model_edge(input logic phi, input logic r);
    int nh, nv, qs;
    bit restart, pop, vis;
    logic [7:0] b;
    m_cyc++;
    if (r) begin
      m_h = 0; m_v = VT - 1;
      exp_q.delete();
      m_out = 0; m_fetched = 0; m_adr = BASE; m_sh = 8'h00;
      e_pix = 1'b0; e_und = 1'b0;
    end else begin
      restart = (m_v == VT - 1) && (m_h == 0);
      nh = (m_h + 1) % HT;
      nv = (nh == 0) ? (m_v + 1) % VT : m_v;
      vis = (nh < HA) && (nv < VA);
      qs = exp_q.size();
      pop = vis && (nh % 8 == 0);
      if (pop) begin
        if (qs == 0) begin
          b = 8'h00;
          e_und = 1'b1;
        end else begin
          b = exp_q.pop_front();
        end
        m_sh = b;
        e_pix = b[7];
      end else if (vis) begin
        m_sh = m_sh << 1;
        e_pix = m_sh[7];
      end else begin
        e_pix = 1'b0;
      end
      if (restart) begin
        exp_q.delete();
        m_out = 0; m_fetched = 0; m_adr = BASE;
      end else if (m_out) begin
        if (m_cyc == m_push_at) begin
          exp_q.push_back(ram_fn(m_adr));
          m_fetched++;
          if (m_fetched < TOTAL) m_adr = m_adr + 16'd1;
          m_out = 0;
        end
      end else if ((qs < 4) && (m_fetched < TOTAL) && phi) begin
        m_out = 1;
        m_push_at = m_cyc + LAT;
      end
      m_h = nh; m_v = nv;
    end
    e_act = (m_h < HA) && (m_v < VA);
    e_hs  = (m_h >= HSS) && (m_h < HSS + HSL);
    e_vs  = (m_v >= VSS) && (m_v < VSS + VSL);
  endtask

  // Driver: apply inputs, clock once, then compare all outputs.
  task automatic tick(input logic phi, input logic r);
    cpu_phi = phi;
    rst = r;
    @(posedge clk);
    model_edge(phi, r);
    #1;
    check1("pixel", pixel, e_pix);
    check1("active", active, e_act);
    check1("hsync", hsync, e_hs);
    check1("vsync", vsync, e_vs);
    check1("underrun", underrun, e_und);
    check16("vid_adr", vid_adr, m_adr);
  endtask

  // mode 0: cpu_phi alternating, 1: held low, 2: random (mostly high)
  task automatic run(input int n, input int mode, input bit chk);
    bit seen0;
    logic phi;
    seen0 = 0;
    for (int i = 0; i < n; i++) begin
      case (mode)
        0:       phi = (i % 2 == 0);
        1:       phi = 1'b0;
        default: phi = ($urandom_range(0, 3) != 0);
      endcase
      tick(phi, 1'b0);
      if (m_v == 0 && m_h == 0) seen0 = 1;
      if (chk) begin
        if (m_v == 0 && m_h < 8) check1("a5_order", pixel, a5_byte[3'(7 - m_h)]);
        if (m_v == 0 && m_h == HSS) check1("hs_start", hsync, 1'b1);
        if (m_v == 0 && m_h == HSS + HSL) check1("hs_end", hsync, 1'b0);
        if (m_v == VSS && m_h == 5) check1("vs_start", vsync, 1'b1);
        if (m_v == VSS + VSL && m_h == 5) check1("vs_end", vsync, 1'b0);
        if (seen0 && m_v == VT - 1 && m_h == 0)
          check16("adr_park", vid_adr, BASE + 16'(TOTAL - 1));
        if (m_v == VT - 1 && m_h == 1) check16("adr_restart", vid_adr, BASE);
      end
    end
  endtask

  initial begin
    a5_byte = 8'hA5;
    m_cyc = 0; m_push_at = 0;
    cpu_phi = 1'b0;
    rst = 1'b1;

    // Reset held for 3 cycles
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    check16("reset_adr", vid_adr, BASE);

    // Alternating slots: prefetch, pixel order, syncs, address park/restart
    run(3 * FRAME, 0, 1'b1);
    check1("no_underrun", underrun, 1'b0);

    // Align to the start of line 0, then starve the fetch side
    for (int i = 0; i < FRAME && !(m_v == 0 && m_h == 0); i++) tick(1'b0 == 1'b0 ? logic'(i % 2 == 0) : 1'b0, 1'b0);
    for (int i = 0; i < FRAME; i++) begin
      tick(1'b0, 1'b0);
      if (m_v == 0 && m_h == 24) check1("starve_byte4", underrun, 1'b0);
      if (m_v == 1 && m_h == 0) begin
        check1("starve_underrun", underrun, 1'b1);
        check1("starve_pixel", pixel, 1'b0);
      end
    end
    run(FRAME, 0, 1'b0);
    check1("underrun_sticky", underrun, 1'b1);

    // Random slot pattern after a fresh reset
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    check1("reset_clears_underrun", underrun, 1'b0);
    run(2 * FRAME, 2, 1'b0);

    // Reset one edge after a grant: the in-flight byte must never land
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    check16("midwait_adr", vid_adr, BASE);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check16("midwait_no_push", vid_adr, BASE);
    run(2 * FRAME, 0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
